// File: rtl/ascon_loader_pkg.sv
// Shared types, constants and helpers for the ASCON share loader.
// Holds the loader FSM encoding, LFSR definition and share-mask helper.
package ascon_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5
    } loader_state_t;

    localparam int                LFSR_W       = 32;
    // Fibonacci taps 32,22,2,1 expressed as bit indices 31,21,1,0
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 32'h8020_0003;
    localparam int                SHARE_BITS   = 8;
    localparam int                RAND_BITS    = 13;
    localparam int                STEPS        = SHARE_BITS + RAND_BITS;
    localparam int                START_CYCLES = 3;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic share0_of(input logic data, input logic s1,
                                       input logic s2, input logic masked);
        return masked ? (data ^ s1 ^ s2) : data;
    endfunction

endpackage

// File: rtl/ascon_lfsr.sv
// 32-bit Fibonacci LFSR stepped STEPS times per clock; each step's
// feedback bit becomes one fresh random output bit.
module ascon_lfsr
    import ascon_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [31:0]      seed,
    input  logic             advance,
    output logic [STEPS-1:0] rnd
);

    logic [LFSR_W-1:0] state_r;
    logic [LFSR_W-1:0] walk_s;
    logic [STEPS-1:0]  rnd_s;

    // Unrolled stepping: bit k is the feedback produced by step k+1
    always_comb begin
        walk_s = state_r;
        rnd_s  = '0;
        for (int k = 0; k < STEPS; k++) begin
            walk_s   = lfsr_step(walk_s);
            rnd_s[k] = walk_s[0];
        end
    end

    // State register; an all-zero seed would lock up, so it becomes 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= '0;
        end else if (seed_load) begin
            state_r <= (seed == 32'h0) ? 32'h1 : seed;
        end else if (advance) begin
            state_r <= walk_s;
        end else begin
            state_r <= state_r;
        end
    end

    assign rnd = rnd_s;

endmodule

// File: rtl/ascon_share_loader.sv
// Collects key/nonce/AD/PT bytes, then streams them bit-serially as three
// Boolean shares plus fresh randomness into an ASCON core and runs it.
module ascon_share_loader
    import ascon_loader_pkg::*;
#(
    parameter int K          = 128,
    parameter int L          = 0,
    parameter int Y          = 0,
    parameter int XOR_SHARES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [31:0] seed,
    output logic [2:0] keyxSI,
    output logic [2:0] noncexSI,
    output logic [2:0] associated_dataxSI,
    output logic [2:0] plain_textxSI,
    output logic [6:0] r_64xSI,
    output logic [2:0] r_128xSI,
    output logic [2:0] r_ptxSI,
    output logic       encryption_startxSI,
    input  logic       encryption_readyxSO,
    output logic       busy,
    output logic       done
);

    localparam int   N      = K / 8 + 16 + L / 8 + Y / 8;
    localparam int   NB     = 8 * N;
    localparam int   S_KN   = (K > 128) ? K : 128;
    localparam int   S_LY   = (L > Y) ? L : Y;
    localparam int   S      = (S_KN > S_LY) ? S_KN : S_LY;
    localparam int   MAXC   = (N > S) ? N : S;
    localparam int   CW     = $clog2(MAXC + 1);
    localparam logic MASKED = (XOR_SHARES != 0);

    loader_state_t    state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [NB-1:0]    buf_r, buf_s;
    logic             accept_s;
    logic [STEPS-1:0] rnd_s;
    logic             key_bit_s, non_bit_s, ad_bit_s, pt_bit_s;
    logic             stream_s, rand_on_s;

    logic       in_ready_r, busy_r, done_r, start_r;
    logic [2:0] key_sh_r, non_sh_r, ad_sh_r, pt_sh_r;
    logic [6:0] r_64_r;
    logic [2:0] r_128_r, r_pt_r;

    assign accept_s = in_valid & in_ready_r;

    ascon_lfsr u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .seed_load (accept_s && (state_r == ST_IDLE)),
        .seed      (seed),
        .advance   (state_r != ST_IDLE),
        .rnd       (rnd_s)
    );

    // Next-state, byte/cycle counter and buffer update
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        buf_s   = buf_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    buf_s   = {buf_r[NB-9:0], in_data};
                    cnt_s   = CW'(1);
                    state_s = ST_LOAD;
                end else begin
                    cnt_s = '0;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    buf_s = {buf_r[NB-9:0], in_data};
                    if (cnt_r == CW'(N - 1)) begin
                        cnt_s   = '0;
                        state_s = ST_STREAM;
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_STREAM: begin
                // Shifting the whole buffer keeps each field's next bit on a fixed tap
                buf_s = {buf_r[NB-2:0], 1'b0};
                if (cnt_r == CW'(S - 1)) begin
                    cnt_s   = '0;
                    state_s = ST_START;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_START: begin
                if (cnt_r == CW'(START_CYCLES - 1)) begin
                    cnt_s   = '0;
                    state_s = ST_WAIT;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_WAIT: begin
                if (encryption_readyxSO) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                buf_s   = '0;
                cnt_s   = '0;
                state_s = ST_IDLE;
            end
            default: begin
                buf_s   = '0;
                cnt_s   = '0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Data taps evaluated against the values the output registers will capture
    assign key_bit_s = (cnt_s < CW'(K)) & buf_s[NB-1];
    assign non_bit_s = (cnt_s < CW'(128)) & buf_s[NB-1-K];

    if (L > 0) begin : g_ad
        assign ad_bit_s = (cnt_s < CW'(L)) & buf_s[L+Y-1];
    end else begin : g_no_ad
        assign ad_bit_s = 1'b0;
    end

    if (Y > 0) begin : g_pt
        assign pt_bit_s = (cnt_s < CW'(Y)) & buf_s[Y-1];
    end else begin : g_no_pt
        assign pt_bit_s = 1'b0;
    end

    assign stream_s  = (state_s == ST_STREAM);
    assign rand_on_s = stream_s || (state_s == ST_START) || (state_s == ST_WAIT);

    // FSM, counter and buffer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            buf_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            buf_r   <= buf_s;
        end
    end

    // Registered outputs, all derived from the upcoming state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            start_r    <= 1'b0;
            key_sh_r   <= 3'b000;
            non_sh_r   <= 3'b000;
            ad_sh_r    <= 3'b000;
            pt_sh_r    <= 3'b000;
            r_64_r     <= 7'd0;
            r_128_r    <= 3'd0;
            r_pt_r     <= 3'd0;
        end else begin
            in_ready_r <= (state_s == ST_IDLE) || (state_s == ST_LOAD);
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= (state_s == ST_DONE);
            start_r    <= (state_s == ST_START);
            key_sh_r   <= stream_s ? {rnd_s[1], rnd_s[0],
                              share0_of(key_bit_s, rnd_s[0], rnd_s[1], MASKED)} : 3'b000;
            non_sh_r   <= stream_s ? {rnd_s[3], rnd_s[2],
                              share0_of(non_bit_s, rnd_s[2], rnd_s[3], MASKED)} : 3'b000;
            ad_sh_r    <= stream_s ? {rnd_s[5], rnd_s[4],
                              share0_of(ad_bit_s, rnd_s[4], rnd_s[5], MASKED)} : 3'b000;
            pt_sh_r    <= stream_s ? {rnd_s[7], rnd_s[6],
                              share0_of(pt_bit_s, rnd_s[6], rnd_s[7], MASKED)} : 3'b000;
            r_64_r     <= rand_on_s ? rnd_s[14:8] : 7'd0;
            r_128_r    <= rand_on_s ? rnd_s[17:15] : 3'd0;
            r_pt_r     <= rand_on_s ? rnd_s[20:18] : 3'd0;
        end
    end

    assign in_ready            = in_ready_r;
    assign busy                = busy_r;
    assign done                = done_r;
    assign encryption_startxSI = start_r;
    assign keyxSI              = key_sh_r;
    assign noncexSI            = non_sh_r;
    assign associated_dataxSI  = ad_sh_r;
    assign plain_textxSI       = pt_sh_r;
    assign r_64xSI             = r_64_r;
    assign r_128xSI            = r_128_r;
    assign r_ptxSI             = r_pt_r;

endmodule

// File: tb/tb_ascon_share_loader.sv
// Scoreboard bench: an unmasked and a masked loader share one stimulus;
// a monitor pops per-cycle expected data bits during each stream.
module tb_ascon_share_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic [31:0] seed;
    logic        ready;

    logic       in_ready0, busy0, done0, start0;
    logic       in_ready1, busy1, done1, start1;
    logic [2:0] key0, non0, ad0, pt0, key1, non1, ad1, pt1;
    logic [6:0] r64_0, r64_1;
    logic [2:0] r128_0, r128_1, rpt_0, rpt_1;

    typedef struct packed { logic k; logic n; logic a; logic p; } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] KEY_A   = 128'h7540e9d968c534f3347c799342ed1264;
    localparam logic [127:0] NONCE_A = 128'h3f0a465dfb478805be644a2627f7c7e8;
    localparam logic [39:0]  AD_A    = 40'h4153434f4e;
    localparam logic [39:0]  PT_A    = 40'h6173636f6e;
    localparam logic [127:0] KEY_B   = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] NONCE_B = 128'haaaaaaaaaaaaaaaa5555555555555555;
    localparam logic [39:0]  AD_B    = 40'h0000000000;
    localparam logic [39:0]  PT_B    = 40'hffffffffff;

    always #5 clk = ~clk;

    ascon_share_loader #(.K(128), .L(40), .Y(40), .XOR_SHARES(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
        .seed(seed), .keyxSI(key0), .noncexSI(non0), .associated_dataxSI(ad0),
        .plain_textxSI(pt0), .r_64xSI(r64_0), .r_128xSI(r128_0), .r_ptxSI(rpt_0),
        .encryption_startxSI(start0), .encryption_readyxSO(ready), .busy(busy0), .done(done0)
    );

    ascon_share_loader #(.K(128), .L(40), .Y(40), .XOR_SHARES(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .seed(seed), .keyxSI(key1), .noncexSI(non1), .associated_dataxSI(ad1),
        .plain_textxSI(pt1), .r_64xSI(r64_1), .r_128xSI(r128_1), .r_ptxSI(rpt_1),
        .encryption_startxSI(start1), .encryption_readyxSO(ready), .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push_expected(input logic [127:0] k, input logic [127:0] n,
                                 input logic [39:0] a, input logic [39:0] p);
        exp_t e;
        for (int i = 0; i < 128; i++) begin
            e.k = k[127-i];
            e.n = n[127-i];
            if (i < 40) begin
                e.a = a[39-i];
                e.p = p[39-i];
            end else begin
                e.a = 1'b0;
                e.p = 1'b0;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic send_bytes(input logic [335:0] all, input bit gap);
        for (int j = 0; j < 42; j++) begin
            @(negedge clk);
            if (gap && j > 0) begin
                in_valid = 1'b0;
                in_data  = 8'hff;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = all[335-8*j -: 8];
            check($sformatf("in_ready_byte%0d", j), 64'({in_ready0, in_ready1}), 64'(2'b11));
        end
    endtask

    task automatic finish_txn(input bit early);
        int  wait_n;
        int  st_n;
        bit  port_nz;
        bit  done_early;
        bit  seen;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'ha5;
        wait_n = 0;
        while (!start0 && wait_n < 400) begin
            @(negedge clk);
            wait_n++;
        end
        in_valid = 1'b0;
        check("start_seen", 64'({start0, start1}), 64'(2'b11));
        st_n = 0;
        port_nz = 1'b0;
        while (start0 && st_n < 10) begin
            st_n++;
            port_nz = port_nz | (|{key0, non0, ad0, pt0, key1, non1, ad1, pt1});
            ready = early && (st_n == 1);
            @(negedge clk);
        end
        ready = 1'b0;
        check("start_len", 64'(st_n), 64'(3));
        check("start_ports_zero", 64'(port_nz), 64'(0));
        done_early = 1'b0;
        repeat (9) begin
            done_early = done_early | done0 | done1;
            @(negedge clk);
        end
        check("no_done_before_ready", 64'(done_early), 64'(0));
        ready = 1'b1;
        seen = 1'b0;
        wait_n = 0;
        while (!seen && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
            seen = done0;
        end
        ready = 1'b0;
        check("done_pulse", 64'({done0, done1, busy0}), 64'(3'b111));
        @(negedge clk);
        check("after_done", 64'({done0, busy0, in_ready0, done1, busy1}), 64'(5'b00100));
        check("idle_outputs_zero", 64'({r64_0, r128_0, rpt_0, start0, key0, non0, ad0, pt0}), 64'(0));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic run_txn(input logic [127:0] k, input logic [127:0] n, input logic [39:0] a,
                           input logic [39:0] p, input logic [31:0] sd, input bit gap, input bit early);
        push_expected(k, n, a, p);
        seed = sd;
        send_bytes({k, n, a, p}, gap);
        finish_txn(early);
    endtask

    // Monitor: detects stream start (in_ready falls while busy) and checks 128 cycles
    initial begin : monitor
        bit         active;
        int         idx;
        bit         prev_rdy;
        bit         rnd_nz;
        logic [7:0] seen1, seen0;
        exp_t       e;
        active = 1'b0;
        idx = 0;
        prev_rdy = 1'b1;
        rnd_nz = 1'b0;
        seen1 = '0;
        seen0 = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                active = 1'b0;
                prev_rdy = 1'b1;
            end else begin
                if (!active && busy0 && prev_rdy && !in_ready0) begin
                    active = 1'b1;
                    idx = 0;
                    rnd_nz = 1'b0;
                    seen1 = '0;
                    seen0 = '0;
                end
                if (active) begin
                    if (idx < 128) begin
                        if (exp_q.size() == 0) begin
                            check($sformatf("queue_underflow_i%0d", idx), 64'(1), 64'(0));
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("share0_i%0d", idx),
                                  64'({key0[0], non0[0], ad0[0], pt0[0]}), 64'({e.k, e.n, e.a, e.p}));
                            check($sformatf("xor3_i%0d", idx),
                                  64'({^key1, ^non1, ^ad1, ^pt1}), 64'({e.k, e.n, e.a, e.p}));
                        end
                        rnd_nz = rnd_nz | (|{r64_0, r128_0, rpt_0});
                        seen1 = seen1 | {key1[2:1], non1[2:1], ad1[2:1], pt1[2:1]};
                        seen0 = seen0 | ~{key1[2:1], non1[2:1], ad1[2:1], pt1[2:1]};
                        if (idx == 31) begin
                            check("rand_nonzero_32", 64'(rnd_nz), 64'(1));
                        end
                        if (idx == 127) begin
                            check("shares_vary", 64'(seen1 & seen0), 64'(8'hff));
                        end
                        idx++;
                    end else begin
                        check("stream_len_start", 64'(start0), 64'(1));
                        active = 1'b0;
                    end
                end
                prev_rdy = in_ready0;
            end
        end
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        seed     = 32'hACE1_0001;
        ready    = 1'b0;
        #12;
        check("reset_outputs0", 64'({in_ready0, busy0, done0, start0, key0, non0, ad0, pt0,
                                     r64_0, r128_0, rpt_0}), 64'({1'b1, 28'b0}));
        check("reset_outputs1", 64'({in_ready1, busy1, done1, start1, key1, non1, ad1, pt1,
                                     r64_1, r128_1, rpt_1}), 64'({1'b1, 28'b0}));
        @(negedge clk);
        rst = 1'b1;

        run_txn(KEY_A, NONCE_A, AD_A, PT_A, 32'hACE1_0001, 1'b0, 1'b0);
        run_txn(KEY_A, NONCE_A, AD_A, PT_A, 32'hACE1_0001, 1'b1, 1'b0);
        run_txn(KEY_B, NONCE_B, AD_B, PT_B, 32'h0000_0000, 1'b0, 1'b1);

        // Abort in the middle of a stream, then reload from scratch
        push_expected(KEY_A, NONCE_A, AD_A, PT_A);
        seed = 32'hACE1_0001;
        send_bytes({KEY_A, NONCE_A, AD_A, PT_A}, 1'b0);
        in_valid = 1'b0;
        repeat (61) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midstream_reset0", 64'({in_ready0, busy0, done0, start0, key0, non0, ad0, pt0,
                                       r64_0, r128_0, rpt_0}), 64'({1'b1, 28'b0}));
        check("midstream_reset1", 64'({in_ready1, busy1, key1, non1, ad1, pt1}), 64'({1'b1, 13'b0}));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_txn(KEY_A, NONCE_A, AD_A, PT_A, 32'hACE1_0001, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
